// File: rtl/med_dose_scheduler.sv
// -----------------------------------------------------------------------------
// med_dose_scheduler
//
// Multi-slot medication dose scheduler. A table of NUM_SLOTS entries holds
// (valid, due time, repeat period). A prescaled time base advances time_now
// once every TICK_DIV clocks; any valid slot whose due time is reached is
// flagged pending. Pending slots are served one at a time, round-robin, over
// a request/ack handshake to the dispenser. Every service, whether acked or
// timed out, produces a one-cycle log record.
//
// Ports
//   clk, rst        clock and synchronous active-high reset
//   cfg_we          write cfg_valid/cfg_time/cfg_period into entry cfg_slot
//   cfg_slot        entry index for the write
//   cfg_valid       1 = enable entry, 0 = delete entry
//   cfg_time        first due time
//   cfg_period      repeat period, 0 = one-shot
//   disp_req        dispense request, held until ack or timeout
//   disp_slot       slot being dispensed, stable while disp_req is high
//   disp_ack        dispenser done, only looked at while requesting
//   log_valid       one-cycle pulse, log record valid
//   log_slot        slot of the record
//   log_time        due time that was serviced
//   log_err         record ended by ack timeout
//   time_now        current time base
//   pending         per-slot pending flags
//   missed_cnt      saturating count of doses that came due while still pending
//   busy            service FSM not idle
// -----------------------------------------------------------------------------
module med_dose_scheduler #(
  parameter int  NUM_SLOTS   = 8,
  parameter int  TIME_W      = 8,
  parameter int  TICK_DIV    = 16,
  parameter int  ACK_TIMEOUT = 64,
  localparam int SLOT_W      = $clog2(NUM_SLOTS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_we,
  input  logic [SLOT_W-1:0]    cfg_slot,
  input  logic                 cfg_valid,
  input  logic [TIME_W-1:0]    cfg_time,
  input  logic [TIME_W-1:0]    cfg_period,
  output logic                 disp_req,
  output logic [SLOT_W-1:0]    disp_slot,
  input  logic                 disp_ack,
  output logic                 log_valid,
  output logic [SLOT_W-1:0]    log_slot,
  output logic [TIME_W-1:0]    log_time,
  output logic                 log_err,
  output logic [TIME_W-1:0]    time_now,
  output logic [NUM_SLOTS-1:0] pending,
  output logic [7:0]           missed_cnt,
  output logic                 busy
);

  localparam int PS_W  = $clog2(TICK_DIV);
  localparam int CNT_W = $clog2(ACK_TIMEOUT);
  localparam logic [PS_W-1:0]  PS_LAST = PS_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_LOG  = 2'd2
  } state_t;

  state_t              state_r;
  state_t              state_next_s;

  logic [PS_W-1:0]     prescaler_r;
  logic                tick_s;
  logic [TIME_W-1:0]   time_next_s;

  logic [NUM_SLOTS-1:0] valid_r;
  logic [TIME_W-1:0]   due_r    [NUM_SLOTS];
  logic [TIME_W-1:0]   period_r [NUM_SLOTS];

  logic [CNT_W-1:0]    to_cnt_r;
  logic [TIME_W-1:0]   grant_time_r;
  logic [SLOT_W-1:0]   rr_ptr_r;
  logic                rewritten_r;

  logic [NUM_SLOTS-1:0] wr_s;
  logic [NUM_SLOTS-1:0] match_s;
  logic [NUM_SLOTS-1:0] miss_s;
  logic [NUM_SLOTS-1:0] log_clr_s;
  logic [NUM_SLOTS-1:0] log_upd_s;
  logic [8:0]          miss_sum_s;

  logic                grant_found_s;
  logic [SLOT_W-1:0]   grant_idx_s;
  logic [SLOT_W-1:0]   cand_s;
  logic                req_exit_s;
  logic                req_err_s;

  assign tick_s      = (prescaler_r == PS_LAST);
  assign time_next_s = time_now + TIME_W'(1'b1);

  // Prescaler and time base.
  always_ff @(posedge clk) begin
    if (rst) begin
      prescaler_r <= '0;
      time_now    <= '0;
    end else begin
      prescaler_r <= tick_s ? '0 : prescaler_r + PS_W'(1'b1);
      if (tick_s) begin
        time_now <= time_next_s;
      end
    end
  end

  // Per-slot write, due-match, miss and end-of-service decode.
  // The match compares against the value time_now takes on this edge, so a
  // slot becomes pending on the same edge time_now reaches its due time.
  always_comb begin
    wr_s       = '0;
    match_s    = '0;
    miss_s     = '0;
    log_clr_s  = '0;
    log_upd_s  = '0;
    miss_sum_s = {1'b0, missed_cnt};
    for (int i = 0; i < NUM_SLOTS; i++) begin
      wr_s[i]      = cfg_we && (cfg_slot == SLOT_W'(i));
      match_s[i]   = tick_s && valid_r[i] && (due_r[i] == time_next_s);
      miss_s[i]    = match_s[i] && pending[i] && !wr_s[i];
      log_clr_s[i] = (state_r == ST_LOG) && (disp_slot == SLOT_W'(i));
      // A slot reprogrammed during its own service keeps the new settings.
      log_upd_s[i] = log_clr_s[i] && !rewritten_r;
      miss_sum_s   = miss_sum_s + {8'd0, miss_s[i]};
    end
  end

  // Round-robin search: first pending slot strictly after rr_ptr, wrapping
  // round to rr_ptr itself last. Walking from the far end lets the nearest
  // hit overwrite the others.
  always_comb begin
    grant_found_s = 1'b0;
    grant_idx_s   = '0;
    cand_s        = '0;
    for (int k = NUM_SLOTS; k >= 1; k--) begin
      cand_s        = rr_ptr_r + SLOT_W'(k);
      grant_idx_s   = pending[cand_s] ? cand_s : grant_idx_s;
      grant_found_s = grant_found_s | pending[cand_s];
    end
  end

  // Service FSM next-state logic.
  always_comb begin
    state_next_s = state_r;
    req_exit_s   = 1'b0;
    req_err_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (grant_found_s) begin
          state_next_s = ST_REQ;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        // An ack arriving on the last allowed cycle still counts as an ack.
        if (disp_ack) begin
          state_next_s = ST_LOG;
          req_exit_s   = 1'b1;
        end else if (to_cnt_r == TO_LAST) begin
          state_next_s = ST_LOG;
          req_exit_s   = 1'b1;
          req_err_s    = 1'b1;
        end else begin
          state_next_s = ST_REQ;
        end
      end
      ST_LOG: begin
        state_next_s = ST_IDLE;
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // Service FSM state register and handshake / log outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      busy         <= 1'b0;
      disp_req     <= 1'b0;
      disp_slot    <= '0;
      grant_time_r <= '0;
      to_cnt_r     <= '0;
      rr_ptr_r     <= '0;
      rewritten_r  <= 1'b0;
      log_valid    <= 1'b0;
      log_slot     <= '0;
      log_time     <= '0;
      log_err      <= 1'b0;
    end else begin
      state_r   <= state_next_s;
      busy      <= (state_next_s != ST_IDLE);
      log_valid <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (grant_found_s) begin
            disp_req     <= 1'b1;
            disp_slot    <= grant_idx_s;
            grant_time_r <= due_r[grant_idx_s];
            to_cnt_r     <= '0;
            rewritten_r  <= wr_s[grant_idx_s];
          end
        end
        ST_REQ: begin
          rewritten_r <= rewritten_r | wr_s[disp_slot];
          if (req_exit_s) begin
            disp_req  <= 1'b0;
            log_valid <= 1'b1;
            log_slot  <= disp_slot;
            log_time  <= grant_time_r;
            log_err   <= req_err_s;
          end else begin
            to_cnt_r <= to_cnt_r + CNT_W'(1'b1);
          end
        end
        ST_LOG: begin
          rr_ptr_r <= disp_slot;
        end
        default: begin
          disp_req <= 1'b0;
        end
      endcase
    end
  end

  // Slot table: a config write beats the end-of-service reschedule.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (rst) begin
        valid_r[i]  <= 1'b0;
        due_r[i]    <= '0;
        period_r[i] <= '0;
      end else if (wr_s[i]) begin
        valid_r[i]  <= cfg_valid;
        due_r[i]    <= cfg_time;
        period_r[i] <= cfg_period;
      end else if (log_upd_s[i]) begin
        if (period_r[i] != '0) begin
          due_r[i] <= due_r[i] + period_r[i];
        end else begin
          valid_r[i] <= 1'b0;
        end
      end
    end
  end

  // Pending flags and missed-dose counter. Priority per slot: config write
  // clears, a due match sets (even against the end-of-service clear, in
  // which case the dose was already pending and is counted as missed),
  // otherwise the end of service clears.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending    <= '0;
      missed_cnt <= '0;
    end else begin
      missed_cnt <= miss_sum_s[8] ? 8'hFF : miss_sum_s[7:0];
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (wr_s[i]) begin
          pending[i] <= 1'b0;
        end else if (match_s[i]) begin
          pending[i] <= 1'b1;
        end else if (log_clr_s[i]) begin
          pending[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_med_dose_scheduler.sv
// -----------------------------------------------------------------------------
// tb_med_dose_scheduler
//
// Directed bench for med_dose_scheduler. The main instance runs with
// TICK_DIV=4 and covers reset, one-shot service, periodic service across the
// time wrap, round-robin order, ack timeout and reset during a request.
// A second, narrow instance (TIME_W=4, TICK_DIV=2) makes the time base wrap
// quickly so that a dose stuck in a long request comes due again and the
// missed counter can be driven to saturation.
// -----------------------------------------------------------------------------
module tb_med_dose_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;

  logic       cfg_we;
  logic [2:0] cfg_slot;
  logic       cfg_valid;
  logic [7:0] cfg_time;
  logic [7:0] cfg_period;
  logic       disp_req;
  logic [2:0] disp_slot;
  logic       disp_ack;
  logic       log_valid;
  logic [2:0] log_slot;
  logic [7:0] log_time;
  logic       log_err;
  logic [7:0] time_now;
  logic [7:0] pending;
  logic [7:0] missed_cnt;
  logic       busy;

  logic       cfg2_we;
  logic [0:0] cfg2_slot;
  logic       cfg2_valid;
  logic [3:0] cfg2_time;
  logic [3:0] cfg2_period;
  logic       disp2_req;
  logic [0:0] disp2_slot;
  logic       disp2_ack;
  logic       log2_valid;
  logic [0:0] log2_slot;
  logic [3:0] log2_time;
  logic       log2_err;
  logic [3:0] time2_now;
  logic [1:0] pending2;
  logic [7:0] missed2_cnt;
  logic       busy2;

  int checks   = 0;
  int failures = 0;

  med_dose_scheduler #(
    .NUM_SLOTS(8), .TIME_W(8), .TICK_DIV(4), .ACK_TIMEOUT(64)
  ) dut (
    .clk(clk), .rst(rst),
    .cfg_we(cfg_we), .cfg_slot(cfg_slot), .cfg_valid(cfg_valid),
    .cfg_time(cfg_time), .cfg_period(cfg_period),
    .disp_req(disp_req), .disp_slot(disp_slot), .disp_ack(disp_ack),
    .log_valid(log_valid), .log_slot(log_slot), .log_time(log_time),
    .log_err(log_err), .time_now(time_now), .pending(pending),
    .missed_cnt(missed_cnt), .busy(busy)
  );

  med_dose_scheduler #(
    .NUM_SLOTS(2), .TIME_W(4), .TICK_DIV(2), .ACK_TIMEOUT(64)
  ) dut_miss (
    .clk(clk), .rst(rst),
    .cfg_we(cfg2_we), .cfg_slot(cfg2_slot), .cfg_valid(cfg2_valid),
    .cfg_time(cfg2_time), .cfg_period(cfg2_period),
    .disp_req(disp2_req), .disp_slot(disp2_slot), .disp_ack(disp2_ack),
    .log_valid(log2_valid), .log_slot(log2_slot), .log_time(log2_time),
    .log_err(log2_err), .time_now(time2_now), .pending(pending2),
    .missed_cnt(missed2_cnt), .busy(busy2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cfg(input logic [2:0] s, input logic v, input logic [7:0] t, input logic [7:0] p);
    cfg_slot   = s;
    cfg_valid  = v;
    cfg_time   = t;
    cfg_period = p;
    cfg_we     = 1'b1;
    @(negedge clk);
    cfg_we     = 1'b0;
  endtask

  task automatic wait_req(input int bound, input string tag);
    int n = 0;
    while (!disp_req && n < bound) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_req_seen"}, 32'(disp_req), 32'd1);
  endtask

  task automatic ack_and_log(input string tag, input int slot, input int t);
    disp_ack = 1'b1;
    @(negedge clk);
    disp_ack = 1'b0;
    check({tag, "_log_valid"}, 32'(log_valid), 32'd1);
    check({tag, "_log_slot"},  32'(log_slot),  32'(slot));
    check({tag, "_log_time"},  32'(log_time),  32'(t));
    check({tag, "_log_err"},   32'(log_err),   32'd0);
  endtask

  task automatic count_rises(input int cycles, output int rises, output int logs);
    logic prev;
    prev  = disp_req;
    rises = 0;
    logs  = 0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      if (disp_req && !prev) rises++;
      if (log_valid) logs++;
      prev = disp_req;
    end
  endtask

  initial begin
    int n;
    int rises;
    int logs;
    int t2_exp [3];
    int t3a [3];
    int t3b [2];
    t2_exp = '{250, 4, 14};
    t3a    = '{1, 4, 6};
    t3b    = '{7, 1};

    rst = 1'b1;
    cfg_we = 1'b0; cfg_slot = 3'd0; cfg_valid = 1'b0; cfg_time = 8'd0; cfg_period = 8'd0;
    disp_ack = 1'b0;
    cfg2_we = 1'b0; cfg2_slot = 1'b0; cfg2_valid = 1'b0; cfg2_time = 4'd0; cfg2_period = 4'd0;
    disp2_ack = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_disp_req",  32'(disp_req),   32'd0);
    check("rst_log_valid", 32'(log_valid),  32'd0);
    check("rst_time_now",  32'(time_now),   32'd0);
    check("rst_pending",   32'(pending),    32'd0);
    check("rst_missed",    32'(missed_cnt), 32'd0);
    check("rst_busy",      32'(busy),       32'd0);
    rst = 1'b0;

    // T1: one-shot slot 2 due at 3, ack 5 cycles into the request
    cfg(3'd2, 1'b1, 8'd3, 8'd0);
    n = 0;
    while (!pending[2] && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("t1_pending_set", 32'(pending[2]), 32'd1);
    check("t1_time_due",    32'(time_now),   32'd3);
    check("t1_req_not_yet", 32'(disp_req),   32'd0);
    @(negedge clk);
    check("t1_req_next",    32'(disp_req),   32'd1);
    check("t1_disp_slot",   32'(disp_slot),  32'd2);
    check("t1_busy",        32'(busy),       32'd1);
    repeat (4) @(negedge clk);
    check("t1_req_held",    32'(disp_req),   32'd1);
    ack_and_log("t1", 2, 3);
    check("t1_req_dropped", 32'(disp_req),   32'd0);
    @(negedge clk);
    check("t1_pending_clr", 32'(pending[2]), 32'd0);
    check("t1_idle",        32'(busy),       32'd0);
    check("t1_log_pulse",   32'(log_valid),  32'd0);
    count_rises(1100, rises, logs);
    check("t1_no_req_after_wrap", 32'(rises), 32'd0);

    // T2: periodic slot 0, due 250 period 10, across the wrap
    cfg(3'd0, 1'b1, 8'd250, 8'd10);
    for (int i = 0; i < 3; i++) begin
      wait_req(1200, "t2");
      check("t2_disp_slot", 32'(disp_slot), 32'd0);
      check("t2_time_now",  32'(time_now),  32'(t2_exp[i]));
      ack_and_log("t2", 0, t2_exp[i]);
    end
    cfg(3'd0, 1'b0, 8'd0, 8'd0);

    // T3: round robin, slots 1,4,6 due at 2, then 1,7 due at 9
    cfg(3'd1, 1'b1, 8'd2, 8'd0);
    cfg(3'd4, 1'b1, 8'd2, 8'd0);
    cfg(3'd6, 1'b1, 8'd2, 8'd0);
    for (int i = 0; i < 3; i++) begin
      wait_req(1200, "t3a");
      check("t3a_disp_slot", 32'(disp_slot), 32'(t3a[i]));
      ack_and_log("t3a", t3a[i], 2);
    end
    cfg(3'd1, 1'b1, 8'd9, 8'd0);
    cfg(3'd7, 1'b1, 8'd9, 8'd0);
    for (int i = 0; i < 2; i++) begin
      wait_req(200, "t3b");
      check("t3b_disp_slot", 32'(disp_slot), 32'(t3b[i]));
      ack_and_log("t3b", t3b[i], 9);
    end

    // T4: ack timeout on slot 3
    cfg(3'd3, 1'b1, 8'd15, 8'd0);
    wait_req(200, "t4");
    check("t4_disp_slot", 32'(disp_slot), 32'd3);
    n = 1;
    while (n < 200) begin
      @(negedge clk);
      if (!disp_req) break;
      n++;
    end
    check("t4_req_cycles", 32'(n),         32'd64);
    check("t4_log_valid",  32'(log_valid), 32'd1);
    check("t4_log_err",    32'(log_err),   32'd1);
    check("t4_log_slot",   32'(log_slot),  32'd3);
    check("t4_log_time",   32'(log_time),  32'd15);
    @(negedge clk);
    check("t4_pending_clr", 32'(pending[3]), 32'd0);

    // T6: reset while requesting
    cfg(3'd3, 1'b1, 8'd40, 8'd5);
    wait_req(200, "t6");
    repeat (3) @(negedge clk);
    check("t6_req_before_rst", 32'(disp_req), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t6_disp_req", 32'(disp_req),  32'd0);
    check("t6_pending",  32'(pending),   32'd0);
    check("t6_time_now", 32'(time_now),  32'd0);
    check("t6_no_log",   32'(log_valid), 32'd0);
    check("t6_busy",     32'(busy),      32'd0);
    count_rises(1100, rises, logs);
    check("t6_no_req_after_rst", 32'(rises), 32'd0);
    check("t6_no_log_after_rst", 32'(logs),  32'd0);

    // T5: missed doses on the narrow instance, ack never given
    cfg2_slot   = 1'b1;
    cfg2_valid  = 1'b1;
    cfg2_time   = 4'd3;
    cfg2_period = 4'd1;
    cfg2_we     = 1'b1;
    @(negedge clk);
    cfg2_we     = 1'b0;
    n = 0;
    while (!pending2[1] && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("t5_pending_set", 32'(pending2[1]), 32'd1);
    check("t5_missed_0",    32'(missed2_cnt), 32'd0);
    repeat (31) @(negedge clk);
    check("t5_missed_before_wrap", 32'(missed2_cnt), 32'd0);
    @(negedge clk);
    check("t5_missed_after_wrap",  32'(missed2_cnt), 32'd1);
    check("t5_still_pending",      32'(pending2[1]), 32'd1);
    repeat (20000) @(negedge clk);
    check("t5_missed_sat",      32'(missed2_cnt), 32'd255);
    repeat (300) @(negedge clk);
    check("t5_missed_sat_hold", 32'(missed2_cnt), 32'd255);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
